// File: rtl/lift_req_sched.sv
// lift_req_sched -- hall-call scheduler in front of the 4-floor lift FSM.
//
// Latches the six hall-call buttons into a pending set and picks one call at a
// time with a SCAN (sweep) policy. The chosen call is presented to the lift on
// req_code with q_empty low. Completion is tracked through lift_done.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn[5:0]    call pulses: bit0=1U bit1=2U bit2=3U bit3=2D bit4=3D bit5=4D
//   lift_done   done flag from the lift FSM
//   req_code    call code to lift (1U=001 2U=010 3U=011 2D=110 3D=111 4D=100, none=000)
//   q_empty     1 = no call presented
//   pending     registered pending-call set, same bit order as btn
//   floor       last completed target floor (0..3 = floors 1..4)
//   dir         sweep direction, 0=UP 1=DOWN
//   served_cnt  (only with LIFT_SCHED_STATS_EN) saturating count of completed calls
//
// Parameters:
//   BUSY_TO     cycles in BUSY with lift_done still high before the call is
//               treated as complete (zero-move call); 1..(2^TO_W)-1
//   TO_W        width of the busy-timeout counter
//
// Optional feature macro: LIFT_SCHED_STATS_EN

module lift_req_sched #(
   parameter int unsigned BUSY_TO = 4,
   parameter int unsigned TO_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn,
   input  logic       lift_done,
   output logic [2:0] req_code,
   output logic       q_empty,
   output logic [5:0] pending,
   output logic [1:0] floor,
   output logic       dir
`ifdef LIFT_SCHED_STATS_EN
   ,
   output logic [15:0] served_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESENT,
      S_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t          state, state_nxt;
   logic [TO_W-1:0] cnt, cnt_nxt;
   logic [2:0]      code_nxt;
   logic [5:0]      pend_clr;
   logic [5:0]      pend_nxt;
   logic [1:0]      floor_nxt;
   logic            dir_nxt;
   logic            q_empty_nxt;
   logic            complete;

   logic [2:0]      sel_idx;
   logic [2:0]      sel_code;

   // Call index (btn bit) to lift request code.
   function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = 3'b001;
         3'd1:    c = 3'b010;
         3'd2:    c = 3'b011;
         3'd3:    c = 3'b110;
         3'd4:    c = 3'b111;
         3'd5:    c = 3'b100;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

   // Request code to its target floor.
   function automatic logic [1:0] code_to_tgt(input logic [2:0] code);
      logic [1:0] t;
      case (code)
         3'b001:  t = 2'd0;
         3'b010:  t = 2'd1;
         3'b011:  t = 2'd2;
         3'b110:  t = 2'd1;
         3'b111:  t = 2'd2;
         3'b100:  t = 2'd3;
         default: t = 2'd0;
      endcase
      return t;
   endfunction

   // Request code to its one-hot pending bit.
   function automatic logic [5:0] code_to_bit(input logic [2:0] code);
      logic [5:0] b;
      case (code)
         3'b001:  b = 6'b000001;
         3'b010:  b = 6'b000010;
         3'b011:  b = 6'b000100;
         3'b110:  b = 6'b001000;
         3'b111:  b = 6'b010000;
         3'b100:  b = 6'b100000;
         default: b = 6'b000000;
      endcase
      return b;
   endfunction

   // SCAN selection. Up-call targets are 0,1,2 (bits 0..2) and down-call
   // targets are 1,2,3 (bits 3..5), so "ascending target" is ascending bit
   // index within each direction. The third group needs no floor test: any
   // call matching the first group's floor test was already taken there.
   always_comb begin
      sel_idx = 3'd0;
      if (!dir) begin
         if      (pending[0] && floor == 2'd0) sel_idx = 3'd0;
         else if (pending[1] && floor <= 2'd1) sel_idx = 3'd1;
         else if (pending[2] && floor <= 2'd2) sel_idx = 3'd2;
         else if (pending[5])                  sel_idx = 3'd5;
         else if (pending[4])                  sel_idx = 3'd4;
         else if (pending[3])                  sel_idx = 3'd3;
         else if (pending[0])                  sel_idx = 3'd0;
         else if (pending[1])                  sel_idx = 3'd1;
         else if (pending[2])                  sel_idx = 3'd2;
      end else begin
         if      (pending[5] && floor == 2'd3) sel_idx = 3'd5;
         else if (pending[4] && floor >= 2'd2) sel_idx = 3'd4;
         else if (pending[3] && floor >= 2'd1) sel_idx = 3'd3;
         else if (pending[0])                  sel_idx = 3'd0;
         else if (pending[1])                  sel_idx = 3'd1;
         else if (pending[2])                  sel_idx = 3'd2;
         else if (pending[5])                  sel_idx = 3'd5;
         else if (pending[4])                  sel_idx = 3'd4;
         else if (pending[3])                  sel_idx = 3'd3;
      end
   end

   assign sel_code = idx_to_code(sel_idx);

   always_comb begin
      state_nxt = state;
      code_nxt  = req_code;
      cnt_nxt   = cnt;
      floor_nxt = floor;
      dir_nxt   = dir;
      pend_clr  = '0;
      complete  = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (|pending) begin
               code_nxt  = sel_code;
               dir_nxt   = (sel_idx >= 3'd3);
               state_nxt = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (lift_done) begin
               pend_clr  = code_to_bit(req_code);
               cnt_nxt   = '0;
               state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!lift_done)
               state_nxt = S_WAIT_DONE;
            else if (cnt == TO_W'(BUSY_TO - 1))
               complete = 1'b1;
            else
               cnt_nxt = cnt + TO_W'(1);
         end
         S_WAIT_DONE: begin
            if (lift_done)
               complete = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (complete) begin
         floor_nxt = code_to_tgt(req_code);
         code_nxt  = '0;
         state_nxt = S_IDLE;
      end
   end

   // A press on the same edge as acceptance re-arms the call (set wins).
   assign pend_nxt    = (pending & ~pend_clr) | btn;
   assign q_empty_nxt = (state_nxt != S_PRESENT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         req_code <= '0;
         q_empty  <= 1'b1;
         pending  <= '0;
         floor    <= '0;
         dir      <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         req_code <= code_nxt;
         q_empty  <= q_empty_nxt;
         pending  <= pend_nxt;
         floor    <= floor_nxt;
         dir      <= dir_nxt;
         cnt      <= cnt_nxt;
      end
   end

`ifdef LIFT_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         served_cnt <= '0;
      else if (complete && served_cnt != '1)
         served_cnt <= served_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lift_req_sched.sv
// Self-checking bench for lift_req_sched: a directed vector table, hand-written
// SCAN-order / timeout / async-reset sequences, and a randomized run. A
// behavioural model of the scheduler is compared against the DUT every cycle.

module tb_lift_req_sched;

   localparam int BUSY_TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] btn;
   logic       lift_done;
   logic [2:0] req_code;
   logic       q_empty;
   logic [5:0] pending;
   logic [1:0] floor;
   logic       dir;
`ifdef LIFT_SCHED_STATS_EN
   logic [15:0] served_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit run_chk = 1'b0;

   lift_req_sched #(.BUSY_TO(BUSY_TO), .TO_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .lift_done (lift_done),
      .req_code  (req_code),
      .q_empty   (q_empty),
      .pending   (pending),
      .floor     (floor),
      .dir       (dir)
`ifdef LIFT_SCHED_STATS_EN
      ,
      .served_cnt(served_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Calls indexed 0..5 in btn order; 0..2 are up-calls, 3..5 down-calls.
   function automatic int tgt_of(input int i);
      return (i < 3) ? i : i - 2;
   endfunction

   function automatic int code_of(input int i);
      if (i < 3)  return i + 1;
      if (i == 5) return 4;
      return i + 3;
   endfunction

   function automatic int idx_of(input int code);
      for (int i = 0; i < 6; i++)
         if (code_of(i) == code) return i;
      return 0;
   endfunction

   // Rank every pending call by (group, order within group); lowest wins.
   function automatic int pick(input logic [5:0] p, input int fl, input logic d);
      int best = -1;
      int br   = 1000;
      int r;
      int t;
      for (int i = 0; i < 6; i++) begin
         if (p[i]) begin
            t = tgt_of(i);
            if (!d) begin
               if (i < 3 && t >= fl) r = t;
               else if (i >= 3)      r = 10 + (3 - t);
               else                  r = 20 + t;
            end else begin
               if (i >= 3 && t <= fl) r = 3 - t;
               else if (i < 3)        r = 10 + t;
               else                   r = 20 + (3 - t);
            end
            if (r < br) begin
               br   = r;
               best = i;
            end
         end
      end
      return best;
   endfunction

   logic [5:0] m_pend = '0;
   int         m_ph = 0;        // 0 idle, 1 presenting, 2 busy, 3 waiting for done
   int         m_code = 0;
   int         m_floor = 0;
   logic       m_dir = 1'b0;
   int         m_cnt = 0;
   int         m_served = 0;

   always @(posedge clk or negedge rst_n) begin : model
      logic [5:0] clr;
      int         k;
      bit         fin;
      if (!rst_n) begin
         m_pend   <= '0;
         m_ph     <= 0;
         m_code   <= 0;
         m_floor  <= 0;
         m_dir    <= 1'b0;
         m_cnt    <= 0;
         m_served <= 0;
      end else begin
         clr = '0;
         fin = 1'b0;
         case (m_ph)
            0: if (m_pend != 0) begin
                  k = pick(m_pend, m_floor, m_dir);
                  m_code <= code_of(k);
                  m_dir  <= (k >= 3);
                  m_ph   <= 1;
               end
            1: if (lift_done) begin
                  clr   = 6'(1) << idx_of(m_code);
                  m_cnt <= 0;
                  m_ph  <= 2;
               end
            2: if (!lift_done)                m_ph <= 3;
               else if (m_cnt == BUSY_TO - 1) fin = 1'b1;
               else                           m_cnt <= m_cnt + 1;
            default: if (lift_done) fin = 1'b1;
         endcase
         if (fin) begin
            m_floor  <= tgt_of(idx_of(m_code));
            m_code   <= 0;
            m_ph     <= 0;
            m_served <= (m_served < 65535) ? m_served + 1 : m_served;
         end
         m_pend <= (m_pend & ~clr) | btn;
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         chk("model_req_code", req_code, m_code);
         chk("model_q_empty", q_empty, (m_ph != 1));
         chk("model_pending", pending, m_pend);
         chk("model_floor", floor, m_floor);
         chk("model_dir", dir, m_dir);
`ifdef LIFT_SCHED_STATS_EN
         chk("model_served_cnt", served_cnt, m_served);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n     = 1'b0;
      btn       = '0;
      lift_done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [5:0] b);
      btn = b;
      @(posedge clk);
      #1;
      btn = '0;
   endtask

   task automatic wait_present(input string nm, input int exp);
      bit got = 1'b0;
      lift_done = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
         @(posedge clk);
         #1;
         if (q_empty == 1'b0) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: no call presented within 20 cycles, expected code %0d", nm, exp);
      end else begin
         chk(nm, req_code, exp);
      end
   endtask

   task automatic complete_call();
      lift_done = 1'b1;
      @(posedge clk); #1;   // accepted
      lift_done = 1'b0;
      @(posedge clk); #1;   // lift moving
      lift_done = 1'b1;
      @(posedge clk); #1;   // completed
   endtask

   task automatic run_call(input string nm, input int exp);
      wait_present(nm, exp);
      complete_call();
   endtask

   typedef struct {
      logic [5:0] btn;
      logic       done;
      logic [2:0] code;
      logic       qe;
      logic [5:0] pend;
      logic [1:0] flr;
      logic       d;
   } vec_t;

   vec_t tbl[21];

   initial begin
      // btn, lift_done | expected req_code, q_empty, pending, floor, dir after the edge
      tbl[0]  = '{6'h04, 1'b1, 3'd0, 1'b1, 6'h04, 2'd0, 1'b0};
      tbl[1]  = '{6'h00, 1'b1, 3'd3, 1'b0, 6'h04, 2'd0, 1'b0};
      tbl[2]  = '{6'h00, 1'b1, 3'd3, 1'b1, 6'h00, 2'd0, 1'b0};
      tbl[3]  = '{6'h00, 1'b0, 3'd3, 1'b1, 6'h00, 2'd0, 1'b0};
      tbl[4]  = '{6'h00, 1'b0, 3'd3, 1'b1, 6'h00, 2'd0, 1'b0};
      tbl[5]  = '{6'h00, 1'b0, 3'd3, 1'b1, 6'h00, 2'd0, 1'b0};
      tbl[6]  = '{6'h00, 1'b1, 3'd0, 1'b1, 6'h00, 2'd2, 1'b0};
      tbl[7]  = '{6'h20, 1'b1, 3'd0, 1'b1, 6'h20, 2'd2, 1'b0};
      tbl[8]  = '{6'h00, 1'b1, 3'd4, 1'b0, 6'h20, 2'd2, 1'b1};
      tbl[9]  = '{6'h20, 1'b1, 3'd4, 1'b1, 6'h20, 2'd2, 1'b1};
      tbl[10] = '{6'h00, 1'b1, 3'd4, 1'b1, 6'h20, 2'd2, 1'b1};
      tbl[11] = '{6'h00, 1'b1, 3'd4, 1'b1, 6'h20, 2'd2, 1'b1};
      tbl[12] = '{6'h00, 1'b1, 3'd4, 1'b1, 6'h20, 2'd2, 1'b1};
      tbl[13] = '{6'h00, 1'b1, 3'd0, 1'b1, 6'h20, 2'd3, 1'b1};
      tbl[14] = '{6'h00, 1'b0, 3'd4, 1'b0, 6'h20, 2'd3, 1'b1};
      tbl[15] = '{6'h01, 1'b0, 3'd4, 1'b0, 6'h21, 2'd3, 1'b1};
      tbl[16] = '{6'h00, 1'b0, 3'd4, 1'b0, 6'h21, 2'd3, 1'b1};
      tbl[17] = '{6'h00, 1'b1, 3'd4, 1'b1, 6'h01, 2'd3, 1'b1};
      tbl[18] = '{6'h00, 1'b0, 3'd4, 1'b1, 6'h01, 2'd3, 1'b1};
      tbl[19] = '{6'h00, 1'b1, 3'd0, 1'b1, 6'h01, 2'd3, 1'b1};
      tbl[20] = '{6'h00, 1'b1, 3'd1, 1'b0, 6'h01, 2'd3, 1'b0};

      rst_n     = 1'b0;
      btn       = '0;
      lift_done = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      run_chk = 1'b1;

      // Idle with no calls.
      repeat (10) @(posedge clk);
      #1;
      chk("idle_q_empty", q_empty, 1);
      chk("idle_req_code", req_code, 0);
      chk("idle_pending", pending, 0);
      chk("idle_floor", floor, 0);

      // Directed vectors: single call, set-wins re-press, busy timeout.
      for (int i = 0; i < 21; i++) begin
         btn       = tbl[i].btn;
         lift_done = tbl[i].done;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_req_code", i), req_code, tbl[i].code);
         chk($sformatf("vec%0d_q_empty", i), q_empty, tbl[i].qe);
         chk($sformatf("vec%0d_pending", i), pending, tbl[i].pend);
         chk($sformatf("vec%0d_floor", i), floor, tbl[i].flr);
         chk($sformatf("vec%0d_dir", i), dir, tbl[i].d);
      end
      btn = '0;

      // UP sweep from floor 1: 3U, 4D, 1U.
      do_reset();
      press(6'b000010);
      run_call("goto2_2U", 2);
      chk("goto2_floor", floor, 1);
      press(6'b100101);
      run_call("up_first_3U", 3);
      run_call("up_second_4D", 4);
      chk("up_after_4D_dir", dir, 1);
      chk("up_after_4D_floor", floor, 3);
      run_call("up_third_1U", 1);
      chk("up_end_dir", dir, 0);
      chk("up_end_floor", floor, 0);

      // DOWN sweep from floor 4: 3D, 2D, 2U.
      press(6'b100000);
      run_call("goto4_4D", 4);
      chk("goto4_dir", dir, 1);
      press(6'b011010);
      run_call("down_first_3D", 7);
      run_call("down_second_2D", 6);
      run_call("down_third_2U", 2);
      chk("down_end_floor", floor, 1);
      chk("down_end_dir", dir, 0);

      // Zero-move call: lift_done never falls, timeout completes the call.
      press(6'b000001);
      run_call("to_pre_1U", 1);
      press(6'b000010);
      wait_present("to_2U", 2);
      lift_done = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < BUSY_TO - 1; i++) begin
         @(posedge clk); #1;
         chk($sformatf("to_busy%0d_req_code", i), req_code, 2);
      end
      @(posedge clk); #1;
      chk("to_done_req_code", req_code, 0);
      chk("to_done_floor", floor, 1);
      chk("to_done_q_empty", q_empty, 1);
      @(posedge clk); #1;
      chk("to_idle_q_empty", q_empty, 1);

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         btn       = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
         lift_done = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      btn       = '0;
      lift_done = 1'b1;

      // Async reset while BUSY with 3D pending.
      do_reset();
      press(6'b001000);
      wait_present("rst_pre_2D", 6);
      btn       = 6'b010000;
      lift_done = 1'b1;
      @(posedge clk); #1;
      btn = '0;
      chk("rst_pre_pending", pending, 6'b010000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_q_empty", q_empty, 1);
      chk("rst_async_req_code", req_code, 0);
      chk("rst_async_pending", pending, 0);
      chk("rst_async_floor", floor, 0);
      chk("rst_async_dir", dir, 0);
`ifdef LIFT_SCHED_STATS_EN
      chk("rst_async_served", served_cnt, 0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      press(6'b000001);
      run_call("post_rst_1U", 1);
      press(6'b000010);
      run_call("post_rst_2U", 2);
      chk("post_rst_floor", floor, 1);
`ifdef LIFT_SCHED_STATS_EN
      chk("post_rst_served", served_cnt, 2);
`endif

      run_chk = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
